etai_error_monitor: RTL

- On-chip error-characterisation controller for the ETAI approximate adder.
- On a start request it generates pseudo-random operand pairs, drives one internal ETAI instance and an exact reference addition, and accumulates error count, sum of error distance and maximum error distance.
- Used for silicon/FPGA measurement of ER/MED/NMED; the divisions (MED = sum_ed/tests_run, etc.) are done by software.

---
 rtl/etai_mon_pkg.sv | 15 +
 rtl/etai.sv | 36 +++
 rtl/etai_lfsr32.sv | 35 +++
 rtl/etai_error_monitor.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/etai_mon_pkg.sv
// Shared types and constants for the ETAI error-characterisation monitor.
package etai_mon_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  // Feedback taps for x^32 + x^22 + x^2 + x + 1 (bits 31, 21, 1, 0).
  localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'hACE1_2468;

endpackage

// File: rtl/etai.sv
// Error-Tolerant Adder type I: exact upper part [N-1:K], carry-free lower part [K-1:0].
// Expects 1 <= K <= N-1.
module etai #(
  parameter int N = 16,
  parameter int K = 12
) (
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  output logic [N-1:0] S,
  output logic         Cout
);

  logic [N-K:0] hi_sum;
  logic [K-1:0] lo_sum;
  logic         sat;

  // Lower part scans MSB->LSB; the first 1+1 position and everything below it saturate to 1.
  always_comb begin
    hi_sum = {1'b0, X[N-1:K]} + {1'b0, Y[N-1:K]};
    lo_sum = '0;
    sat    = 1'b0;
    for (int i = K - 1; i >= 0; i--) begin
      if (sat) begin
        lo_sum[i] = 1'b1;
      end else if (X[i] && Y[i]) begin
        lo_sum[i] = 1'b1;
        sat       = 1'b1;
      end else begin
        lo_sum[i] = X[i] ^ Y[i];
      end
    end
    S    = {hi_sum[N-K-1:0], lo_sum};
    Cout = hi_sum[N-K];
  end

endmodule

// File: rtl/etai_lfsr32.sv
// 32-bit Fibonacci LFSR operand source; a zero seed is swapped for a fixed non-zero seed.
module etai_lfsr32
  import etai_mon_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] seed,
  input  logic        step,
  output logic [31:0] q
);

  logic [31:0] lfsr_q, lfsr_d;

  // Next-state: load has priority over step.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load) begin
      lfsr_d = (seed == 32'd0) ? DEFAULT_SEED : seed;
    end else if (step) begin
      lfsr_d = {lfsr_q[30:0], ^(lfsr_q & LFSR_TAPS)};
    end else begin
      lfsr_d = lfsr_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 32'd0;
    else     lfsr_q <= lfsr_d;
  end

  assign q = lfsr_q;

endmodule

// File: rtl/etai_error_monitor.sv
// Measurement controller: feeds LFSR operands to an ETAI instance and accumulates
// error count, sum of error distance and maximum error distance against exact addition.
module etai_error_monitor
  import etai_mon_pkg::*;
#(
  parameter int N     = 16,
  parameter int K     = 12,
  parameter int CNT_W = 32,
  parameter int ACC_W = 48
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_tests,
  input  logic [31:0]      seed,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tests_run,
  output logic [CNT_W-1:0] err_count,
  output logic [ACC_W-1:0] sum_ed,
  output logic [N-1:0]     max_ed
);

  mon_state_e       state_q, state_d;
  logic [CNT_W-1:0] num_q, num_d, issued_q, issued_d;
  logic [N-1:0]     x_q, y_q, ed_q, ed_d;
  logic             v1_q, v2_q;
  logic [CNT_W-1:0] tests_run_q, tests_run_d, err_count_q, err_count_d;
  logic [ACC_W-1:0] sum_ed_q, sum_ed_d;
  logic [N-1:0]     max_ed_q, max_ed_d;
  logic             lfsr_load, issue, clear;
  logic [31:0]      lfsr_q;
  logic [N-1:0]     approx_sum, exact_sum;
  logic             etai_cout_unused;

  etai_lfsr32 u_lfsr (
    .clk  (clk),
    .rst  (rst),
    .load (lfsr_load),
    .seed (seed),
    .step (issue),
    .q    (lfsr_q)
  );

  etai #(.N(N), .K(K)) u_etai (
    .X    (x_q),
    .Y    (y_q),
    .S    (approx_sum),
    .Cout (etai_cout_unused)
  );

  // Controller: accepts start only in IDLE, issues one pair per RUN cycle.
  always_comb begin
    state_d   = state_q;
    num_d     = num_q;
    issued_d  = issued_q;
    lfsr_load = 1'b0;
    issue     = 1'b0;
    clear     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          clear    = 1'b1;
          num_d    = num_tests;
          issued_d = '0;
          if (num_tests != '0) begin
            lfsr_load = 1'b1;
            state_d   = RUN;
          end else begin
            state_d = DONE;
          end
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        issue    = 1'b1;
        issued_d = issued_q + CNT_W'(1);
        if (issued_q == num_q - CNT_W'(1)) state_d = DRAIN;
        else                               state_d = RUN;
      end
      DRAIN: begin
        if (!v1_q && !v2_q) state_d = DONE;
        else                state_d = DRAIN;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Error distance is an N-bit magnitude; carry-outs of both sums are discarded.
  always_comb begin
    exact_sum = x_q + y_q;
    if (approx_sum >= exact_sum) ed_d = approx_sum - exact_sum;
    else                         ed_d = exact_sum - approx_sum;
  end

  // Result accumulators: cleared on an accepted start, updated by each retiring pair.
  always_comb begin
    tests_run_d = tests_run_q;
    err_count_d = err_count_q;
    sum_ed_d    = sum_ed_q;
    max_ed_d    = max_ed_q;
    if (clear) begin
      tests_run_d = '0;
      err_count_d = '0;
      sum_ed_d    = '0;
      max_ed_d    = '0;
    end else if (v2_q) begin
      tests_run_d = tests_run_q + CNT_W'(1);
      err_count_d = err_count_q + CNT_W'(ed_q != '0);
      sum_ed_d    = sum_ed_q + ACC_W'(ed_q);
      max_ed_d    = (ed_q > max_ed_q) ? ed_q : max_ed_q;
    end else begin
      tests_run_d = tests_run_q;
    end
  end

  // All sequential state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      num_q       <= '0;
      issued_q    <= '0;
      x_q         <= '0;
      y_q         <= '0;
      v1_q        <= 1'b0;
      ed_q        <= '0;
      v2_q        <= 1'b0;
      tests_run_q <= '0;
      err_count_q <= '0;
      sum_ed_q    <= '0;
      max_ed_q    <= '0;
    end else begin
      state_q  <= state_d;
      num_q    <= num_d;
      issued_q <= issued_d;
      if (issue) begin
        x_q <= lfsr_q[N-1:0];
        y_q <= lfsr_q[31:32-N];
      end
      v1_q <= issue;
      if (v1_q) ed_q <= ed_d;
      v2_q        <= v1_q;
      tests_run_q <= tests_run_d;
      err_count_q <= err_count_d;
      sum_ed_q    <= sum_ed_d;
      max_ed_q    <= max_ed_d;
    end
  end

  assign busy      = (state_q == RUN) || (state_q == DRAIN);
  assign done      = (state_q == DONE);
  assign tests_run = tests_run_q;
  assign err_count = err_count_q;
  assign sum_ed    = sum_ed_q;
  assign max_ed    = max_ed_q;

endmodule
